dist_fifo: RTL and testbench

- Parametrised synchronous FIFO whose storage is a distributed RAM: single write port (synchronous write), asynchronous read.
- Generalises the fixed 16x8 distributed-memory experiment to WIDTH x DEPTH, with valid/ready handshakes, occupancy count, full/empty flags and a synchronous clear.
- Sits between a producer and a consumer in the lab datapath, e.g. as a queue ahead of the display/output stage.

---
 rtl/dist_fifo_pkg.sv | 11 +
 rtl/dist_ram_sdp.sv | 26 ++
 rtl/dist_fifo.sv | 90 +++++++++
 tb/tb_dist_fifo.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/dist_fifo_pkg.sv
// Shared definitions for the distributed-RAM FIFO: default depth and the
// pointer width helper (address bits plus one wrap bit).
package dist_fifo_pkg;

  localparam int DEF_DEPTH = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dist_ram_sdp.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
// Contents are never reset.
module dist_ram_sdp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dist_fifo.sv
// First-word-fall-through FIFO over a distributed RAM with valid/ready
// handshakes, occupancy count and synchronous clear.
// Define DIST_FIFO_ALMOST_EN to add almost_full/almost_empty outputs.
module dist_fifo
  import dist_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEF_DEPTH
`ifdef DIST_FIFO_ALMOST_EN
  ,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
`endif
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [ptr_w(DEPTH)-1:0] count,
`ifdef DIST_FIFO_ALMOST_EN
  output logic                    almost_full,
  output logic                    almost_empty,
`endif
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          push, pop;

  // Low bits equal with differing wrap bits means the writer is a full lap ahead.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign in_ready  = rstn && !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef DIST_FIFO_ALMOST_EN
  assign almost_full  = (int'(count) >= AF_LEVEL);
  assign almost_empty = (int'(count) <= AE_LEVEL);
`endif

  // Clear wins over push and pop; the read pointer snaps to the write pointer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  dist_ram_sdp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push && !clr),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_dist_fifo.sv
// Directed-vector bench for dist_fifo (WIDTH=8, DEPTH=16) with a queue
// scoreboard for the randomised streaming phase.
module tb_dist_fifo;

  logic       clk = 1'b0;
  logic       rstn, clr, in_valid, in_ready, out_valid, out_ready, full, empty;
  logic [7:0] in_data, out_data;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dist_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  typedef struct {
    bit         clr, iv, ordy;
    logic [7:0] din;
    int         cnt;
    bit         emp, ful, ov;
    logic [7:0] dout;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit c, bit iv, int din, bit ordy,
                              int cnt, bit emp, bit ful, bit ov, int dout);
    vec_t v;
    v.clr = c; v.iv = iv; v.din = 8'(din); v.ordy = ordy;
    v.cnt = cnt; v.emp = emp; v.ful = ful; v.ov = ov; v.dout = 8'(dout);
    return v;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] nx [8];
    logic [7:0] q[$];
    logic [7:0] exp_d;
    bit         pushed, popped;
    int         sent, cyc;

    rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    rstn = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Fill to full, then a rejected 17th push
    for (int i = 0; i < 16; i++) tv.push_back(mk(0, 1, i, 0, i + 1, 0, i == 15, 1, 0));
    tv.push_back(mk(0, 1, 8'hAA, 0, 16, 0, 1, 1, 0));
    // Drain in order
    for (int i = 0; i < 16; i++) tv.push_back(mk(0, 0, 0, 1, 15 - i, i == 15, 0, i != 15, i + 1));
    // Build to 5, then three push+pop cycles
    for (int i = 0; i < 5; i++) tv.push_back(mk(0, 1, 8'h20 + i, 0, i + 1, 0, 0, 1, 8'h20));
    for (int i = 0; i < 3; i++) tv.push_back(mk(0, 1, 8'h25 + i, 1, 5, 0, 0, 1, 8'h21 + i));
    // Top up to full (queue 23..27,30..3A), then push+pop while full
    for (int i = 0; i < 11; i++) tv.push_back(mk(0, 1, 8'h30 + i, 0, 6 + i, 0, i == 10, 1, 8'h23));
    tv.push_back(mk(0, 1, 8'hBB, 1, 15, 0, 0, 1, 8'h24));
    nx = '{8'h25, 8'h26, 8'h27, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
    for (int i = 0; i < 8; i++) tv.push_back(mk(0, 0, 0, 1, 14 - i, 0, 0, 1, nx[i]));
    // Clear at count 7 with a simultaneous push of 0x55
    tv.push_back(mk(1, 1, 8'h55, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 1, 8'h66, 0, 1, 0, 0, 1, 8'h66));
    tv.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0));

    foreach (tv[k]) begin
      clr = tv[k].clr; in_valid = tv[k].iv; in_data = tv[k].din; out_ready = tv[k].ordy;
      step();
      chk($sformatf("v%0d_count", k), count, tv[k].cnt);
      chk($sformatf("v%0d_empty", k), empty, tv[k].emp);
      chk($sformatf("v%0d_full", k), full, tv[k].ful);
      chk($sformatf("v%0d_out_valid", k), out_valid, tv[k].ov);
      chk($sformatf("v%0d_in_ready", k), in_ready, !tv[k].ful);
      if (tv[k].ov) chk($sformatf("v%0d_out_data", k), out_data, tv[k].dout);
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // Randomised stream against a queue scoreboard; pointers wrap repeatedly
    sent = 0; cyc = 0;
    while ((sent < 40 || q.size() > 0) && cyc < 400) begin
      in_valid  = (sent < 40) && ($urandom_range(0, 1) == 1);
      in_data   = 8'($urandom);
      out_ready = (sent >= 40) || ($urandom_range(0, 1) == 1);
      pushed = in_valid && (q.size() < 16);
      popped = out_ready && (q.size() > 0);
      if (popped) begin
        exp_d = q.pop_front();
        chk("stream_data", out_data, exp_d);
      end
      if (pushed) begin
        q.push_back(in_data);
        sent++;
      end
      step();
      cyc++;
      chk("stream_count", count, q.size());
    end
    if (cyc >= 400) chk("stream_budget", cyc, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_empty", empty, 1);

    // Reset in the middle of operation discards contents
    in_valid = 1'b1; in_data = 8'h77;
    step(); step();
    chk("mid_count_pre", count, 2);
    in_valid = 1'b0; rstn = 1'b0;
    #1;
    chk("mid_in_ready_low", in_ready, 0);
    step();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    rstn = 1'b1;
    step();
    chk("mid_after_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
